// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through ready/valid FIFO sitting behind the UART receiver.
// Words are written into a register array and shown on the output port in arrival order.
module stream_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Handshake flags depend only on registers and rst, never on the opposite port.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately left out of reset; push already implies rst is low.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: accepted words are queued and compared when popped.
module tb_stream_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] level;

  int n_checks = 0;
  int n_errors = 0;
  logic [N-1:0] sb [$];

  stream_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check state against the model, account handshakes, pass the edge.
  task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy,
                       input logic r, output logic acc);
    logic [N-1:0] exp_word;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    acc = 1'b0;
    #1;
    if (r) begin
      chk("in_ready_in_reset", in_ready, 1'b0);
      sb.delete();
    end else begin
      chk("level", level, sb.size());
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, sb.size() < DEPTH);
      if (out_valid && ordy && sb.size() != 0) begin
        exp_word = sb.pop_front();
        chk("out_data", out_data, exp_word);
      end
      if (iv && in_ready && sb.size() < DEPTH + 1) begin
        sb.push_back(d);
        acc = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    logic acc;
    int idx;
    int budget;

    // Reset, then idle
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("idle_level", level, 0);
    chk("idle_in_ready", in_ready, 1'b1);

    // Single word
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, acc);
    chk("single_acc", acc, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("single_data_hold", out_data, 8'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("single_empty", out_valid, 1'b0);

    // Fill to DEPTH, then offer 0xFF which must not be taken
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, N'(i), 1'b0, 1'b0, acc);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, acc);
    chk("full_reject", acc, 1'b0);
    chk("full_level", level, DEPTH);

    // Drain with the producer still holding 0xFF
    idx = 0;
    budget = 0;
    while (idx == 0 && budget < 100) begin
      cycle(1'b1, 8'hFF, 1'b1, 1'b0, acc);
      if (acc) idx = 1;
      budget++;
    end
    chk("ff_accepted", idx, 1);
    budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      cycle(1'b0, '0, 1'b1, 1'b0, acc);
      budget++;
    end
    chk("drain_done", sb.size(), 0);

    // 40 words with random consumer stalls
    idx = 0;
    budget = 0;
    while ((idx < 40 || sb.size() != 0) && budget < 2000) begin
      cycle(idx < 40, N'(8'h40 + idx), 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) idx++;
      budget++;
    end
    chk("random_all_sent", idx, 40);
    chk("random_drained", sb.size(), 0);

    // Level 5, then push and pop together for 20 cycles
    for (int i = 0; i < 5; i++) cycle(1'b1, N'(8'h80 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, N'(8'h90 + i), 1'b1, 1'b0, acc);
      chk("simul_acc", acc, 1'b1);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("simul_level", level, 5);

    // Grow to 9, then a single reset cycle
    for (int i = 0; i < 4; i++) cycle(1'b1, N'(8'hB0 + i), 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("pre_reset_level", level, 9);
    cycle(1'b0, '0, 1'b1, 1'b1, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("post_reset_level", level, 0);
    chk("post_reset_valid", out_valid, 1'b0);
    chk("post_reset_ready", in_ready, 1'b1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("post_reset_data", out_data, 8'h3C);
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, 1'b0, acc);
    chk("final_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
